irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 137 +++++++++++++
 tb/tb_irq_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_ctrl
//  Description : Interrupt controller for a single-hart core.
//                Four asynchronous edge-triggered sources are synchronised
//                and edge-detected, then latched as pending flags.
//                A mask register gates them.
//                A three-state FSM (IDLE / REQ / SERVICE) raises a level
//                request for the lowest-indexed enabled pending source.
//                It holds the request until the core acknowledges it,
//                then blocks further requests until the handler returns.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         i_irq_in,
  input  logic                       i_mask_we,
  input  logic [NUM_SRC-1:0]         i_mask_wdata,
  input  logic                       i_irq_ack,
  input  logic                       i_irq_mret,
  output logic                       o_interrupt,
  output logic [$clog2(NUM_SRC)-1:0] o_irq_cause,
  output logic [NUM_SRC-1:0]         o_pending,
  output logic [NUM_SRC-1:0]         o_mask,
  output logic                       o_in_service
);

  localparam int c_CW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_SRC-1:0]  r_sync1;
  logic [NUM_SRC-1:0]  r_sync2;
  logic [NUM_SRC-1:0]  r_sync2_d;
  logic [NUM_SRC-1:0]  r_pending;
  logic [NUM_SRC-1:0]  r_mask;
  logic [c_CW-1:0]     r_cause;
  logic [NUM_SRC-1:0]  w_rise;
  logic [NUM_SRC-1:0]  w_enabled;
  logic [NUM_SRC-1:0]  w_clr;
  logic [c_CW-1:0]     w_lowest;
  logic                w_take;
  logic                w_ack_clr;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync2_d <= '0;
    end else begin
      r_sync1   <= i_irq_in;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  // A held level produces exactly one edge, so it triggers only once
  assign w_rise    = r_sync2 & ~r_sync2_d;
  assign w_enabled = r_pending & r_mask;

  // Lowest-indexed enabled source wins; scanning downward leaves the lowest
  always_comb begin
    w_lowest = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_enabled[i]) begin
        w_lowest = c_CW'(i);
      end
    end
  end

  // Next-state logic: acks outside REQ and mrets outside SERVICE fall through
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_ack_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_enabled) begin
          w_state_nxt = S_REQ;
          w_take      = 1'b1;
        end
      end
      S_REQ: begin
        if (i_irq_ack) begin
          w_state_nxt = S_SERVICE;
          w_ack_clr   = 1'b1;
        end
      end
      S_SERVICE: begin
        if (i_irq_mret) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The acknowledged source's bit is cleared; an edge arriving on the same cycle wins
  assign w_clr = w_ack_clr ? (NUM_SRC'(1) << r_cause) : '0;

  // State, pending flags, mask and latched cause
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_mask    <= '1;
      r_cause   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= (r_pending & ~w_clr) | w_rise;
      if (i_mask_we) begin
        r_mask <= i_mask_wdata;
      end
      if (w_take) begin
        r_cause <= w_lowest;
      end
    end
  end

  assign o_interrupt  = (r_state == S_REQ);
  assign o_in_service = (r_state == S_SERVICE);
  assign o_irq_cause  = r_cause;
  assign o_pending    = r_pending;
  assign o_mask       = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Directed, table-driven bench for irq_ctrl with hand-written
//                sequences for held levels and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       irq_ack;
  logic       irq_mret;
  logic       interrupt;
  logic [1:0] irq_cause;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       in_service;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl #(.NUM_SRC(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_irq_in     (irq_in),
    .i_mask_we    (mask_we),
    .i_mask_wdata (mask_wdata),
    .i_irq_ack    (irq_ack),
    .i_irq_mret   (irq_mret),
    .o_interrupt  (interrupt),
    .o_irq_cause  (irq_cause),
    .o_pending    (pending),
    .o_mask       (mask),
    .o_in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] irq;
    logic       mwe;
    logic [3:0] mwd;
    logic       ack;
    logic       mret;
    logic       e_int;
    logic [1:0] e_cause;
    logic [3:0] e_pend;
    logic [3:0] e_mask;
    logic       e_svc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                     input logic ack, input logic mret,
                     input logic e_int, input logic [1:0] e_cause,
                     input logic [3:0] e_pend, input logic [3:0] e_mask,
                     input logic e_svc);
    vec_t v;
    v.irq = irq; v.mwe = mwe; v.mwd = mwd; v.ack = ack; v.mret = mret;
    v.e_int = e_int; v.e_cause = e_cause; v.e_pend = e_pend;
    v.e_mask = e_mask; v.e_svc = e_svc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic e_int, input logic [1:0] e_cause,
                     input logic [3:0] e_pend, input logic [3:0] e_mask,
                     input logic e_svc);
    n_tests++;
    if ({interrupt, irq_cause, pending, mask, in_service} !==
        {e_int, e_cause, e_pend, e_mask, e_svc}) begin
      n_fail++;
      $display("FAIL %s: got int=%b cause=%0d pend=%b mask=%b svc=%b, want int=%b cause=%0d pend=%b mask=%b svc=%b",
               name, interrupt, irq_cause, pending, mask, in_service,
               e_int, e_cause, e_pend, e_mask, e_svc);
    end
  endtask

  // Drive one cycle of inputs after the falling edge, sample 1 ns after the rising edge
  task automatic cyc(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                     input logic ack, input logic mret);
    @(negedge clk);
    irq_in = irq; mask_we = mwe; mask_wdata = mwd; irq_ack = ack; irq_mret = mret;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0;
    irq_ack = 1'b0; irq_mret = 1'b0;

    //  irq     we  wd      ack  mret int cause pend     mask     svc
    // Single source 0 pulse: pending at k+2, request at k+3, held until ack
    add(4'b0001, 0, 4'h0, 0, 0,   0, 2'd0, 4'b0000, 4'hF, 0); // 0
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd0, 4'b0000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd0, 4'b0001, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd0, 4'b0001, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd0, 4'b0001, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 1, 0,   0, 2'd0, 4'b0000, 4'hF, 1); // 5
    add(4'b0000, 0, 4'h0, 0, 1,   0, 2'd0, 4'b0000, 4'hF, 0);
    // Sources 1 and 3 together: 1 first, 3 re-requests one cycle after return
    add(4'b1010, 0, 4'h0, 0, 0,   0, 2'd0, 4'b0000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd0, 4'b0000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd0, 4'b1010, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd1, 4'b1010, 4'hF, 0); // 10
    add(4'b0000, 0, 4'h0, 1, 0,   0, 2'd1, 4'b1000, 4'hF, 1);
    add(4'b0000, 0, 4'h0, 0, 1,   0, 2'd1, 4'b1000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd3, 4'b1000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 1, 0,   0, 2'd3, 4'b0000, 4'hF, 1);
    add(4'b0000, 0, 4'h0, 1, 1,   0, 2'd3, 4'b0000, 4'hF, 0); // 15 ack+mret in SERVICE
    // Masked source 2 is retained, then requests once unmasked
    add(4'b0000, 1, 4'hB, 0, 0,   0, 2'd3, 4'b0000, 4'hB, 0);
    add(4'b0100, 0, 4'h0, 0, 0,   0, 2'd3, 4'b0000, 4'hB, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd3, 4'b0000, 4'hB, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd3, 4'b0100, 4'hB, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd3, 4'b0100, 4'hB, 0); // 20
    add(4'b0000, 1, 4'hF, 0, 0,   0, 2'd3, 4'b0100, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd2, 4'b0100, 4'hF, 0);
    add(4'b0000, 1, 4'h0, 0, 0,   1, 2'd2, 4'b0100, 4'h0, 0); // mask write in REQ
    add(4'b0000, 1, 4'hF, 0, 0,   1, 2'd2, 4'b0100, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 1, 0,   0, 2'd2, 4'b0000, 4'hF, 1); // 25
    add(4'b0000, 0, 4'h0, 0, 1,   0, 2'd2, 4'b0000, 4'hF, 0);
    // Source 0 edge coincident with ack of cause 0: set wins
    add(4'b0001, 0, 4'h0, 0, 0,   0, 2'd2, 4'b0000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd2, 4'b0000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   0, 2'd2, 4'b0001, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd0, 4'b0001, 4'hF, 0); // 30
    add(4'b0001, 0, 4'h0, 0, 0,   1, 2'd0, 4'b0001, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd0, 4'b0001, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 1, 0,   0, 2'd0, 4'b0001, 4'hF, 1);
    add(4'b0000, 0, 4'h0, 0, 1,   0, 2'd0, 4'b0001, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 0,   1, 2'd0, 4'b0001, 4'hF, 0); // 35
    add(4'b0000, 0, 4'h0, 1, 0,   0, 2'd0, 4'b0000, 4'hF, 1);
    add(4'b0000, 0, 4'h0, 0, 1,   0, 2'd0, 4'b0000, 4'hF, 0);
    // Stray ack / mret in IDLE are ignored
    add(4'b0000, 0, 4'h0, 1, 0,   0, 2'd0, 4'b0000, 4'hF, 0);
    add(4'b0000, 0, 4'h0, 0, 1,   0, 2'd0, 4'b0000, 4'hF, 0);

    // Asynchronous reset: outputs settle without a clock edge
    #1 rst = 1'b1;
    #1 chk("reset_state", 0, 2'd0, 4'b0000, 4'hF, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].irq, vecs[i].mwe, vecs[i].mwd, vecs[i].ack, vecs[i].mret);
      chk($sformatf("vec%0d", i), vecs[i].e_int, vecs[i].e_cause,
          vecs[i].e_pend, vecs[i].e_mask, vecs[i].e_svc);
    end

    // Source 3 held high for 20 cycles: exactly one pending set
    cyc(4'b1000, 0, 4'h0, 0, 0); chk("hold_c1", 0, 2'd0, 4'b0000, 4'hF, 0);
    cyc(4'b1000, 0, 4'h0, 0, 0); chk("hold_c2", 0, 2'd0, 4'b0000, 4'hF, 0);
    cyc(4'b1000, 0, 4'h0, 0, 0); chk("hold_c3", 0, 2'd0, 4'b1000, 4'hF, 0);
    cyc(4'b1000, 0, 4'h0, 0, 0); chk("hold_req", 1, 2'd3, 4'b1000, 4'hF, 0);
    cyc(4'b1000, 0, 4'h0, 0, 1); chk("mret_in_req", 1, 2'd3, 4'b1000, 4'hF, 0);
    cyc(4'b1000, 0, 4'h0, 1, 0); chk("hold_ack", 0, 2'd3, 4'b0000, 4'hF, 1);
    for (int c = 7; c <= 20; c++) begin
      cyc(4'b1000, 0, 4'h0, 0, 0);
      chk($sformatf("hold_c%0d", c), 0, 2'd3, 4'b0000, 4'hF, 1);
    end
    cyc(4'b0000, 0, 4'h0, 0, 1); chk("hold_mret", 0, 2'd3, 4'b0000, 4'hF, 0);
    for (int c = 0; c < 3; c++) begin
      cyc(4'b0000, 0, 4'h0, 0, 0);
      chk($sformatf("release_c%0d", c), 0, 2'd3, 4'b0000, 4'hF, 0);
    end

    // Reset in SERVICE with pending = 0110 and a non-default mask
    cyc(4'b0110, 0, 4'h0, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0); chk("pre_rst_pend", 0, 2'd3, 4'b0110, 4'hF, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0); chk("pre_rst_req", 1, 2'd1, 4'b0110, 4'hF, 0);
    cyc(4'b0000, 0, 4'h0, 1, 0); chk("pre_rst_svc", 0, 2'd1, 4'b0100, 4'hF, 1);
    cyc(4'b0010, 1, 4'h3, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0);
    cyc(4'b0000, 0, 4'h0, 0, 0); chk("pre_rst_0110", 0, 2'd1, 4'b0110, 4'h3, 1);
    #2 rst = 1'b1;
    #1 chk("rst_in_service", 0, 2'd0, 4'b0000, 4'hF, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(4'b0000, 0, 4'h0, 0, 0);
      chk($sformatf("post_rst_c%0d", c), 0, 2'd0, 4'b0000, 4'hF, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
